// File: rtl/fifo_rd_stage_if.sv
// Handshake bundle for the FIFO read-side output stage.
// It carries the FIFO read port on one side and the valid/ready stream on the other.
interface fifo_rd_stage_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       level;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data,
        output level
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data,
        input  level
    );
endinterface

// File: rtl/fifo_rd_stage.sv
// Converts a 1-cycle-latency FIFO read port into a first-word-fall-through stream.
// A 2-entry buffer plus one tracked in-flight read gives full throughput with registered outputs.
module fifo_rd_stage #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    fifo_rd_stage_if.master bus
);

    logic [1:0]       occ_r;
    logic             inflight_r;
    logic             m_valid_r;
    logic [WIDTH-1:0] buf0_r;
    logic [WIDTH-1:0] buf1_r;

    logic             pop_s;
    logic             fifo_rd_s;
    logic             cap_idx_s;
    logic [1:0]       pending_s;
    logic [1:0]       occ_nx_s;
    logic [WIDTH-1:0] buf0_nx_s;
    logic [WIDTH-1:0] buf1_nx_s;

    // Pop detection and read-issue decision; a pop frees a slot in the same cycle
    always_comb begin
        pop_s     = m_valid_r & bus.m_ready;
        pending_s = occ_r + {1'b0, inflight_r};
        if (rst && !bus.fifo_empty && ((pending_s < 2'd2) || pop_s)) begin
            fifo_rd_s = 1'b1;
        end else begin
            fifo_rd_s = 1'b0;
        end
    end

    // Next buffer contents: shift on pop, then land the in-flight word behind the survivors
    always_comb begin
        occ_nx_s  = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
        cap_idx_s = pop_s ? (occ_r == 2'd2) : (occ_r == 2'd1);
        buf0_nx_s = (inflight_r && !cap_idx_s) ? bus.fifo_dout
                                               : (pop_s ? buf1_r : buf0_r);
        buf1_nx_s = (inflight_r && cap_idx_s) ? bus.fifo_dout : buf1_r;
    end

    // State registers; reset drops any buffered or in-flight word
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            m_valid_r  <= 1'b0;
            buf0_r     <= {WIDTH{1'b0}};
            buf1_r     <= {WIDTH{1'b0}};
        end else begin
            occ_r      <= occ_nx_s;
            inflight_r <= fifo_rd_s;
            m_valid_r  <= (occ_nx_s != 2'd0);
            buf0_r     <= buf0_nx_s;
            buf1_r     <= buf1_nx_s;
        end
    end

    assign bus.fifo_rd = fifo_rd_s;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = buf0_r;
    assign bus.level   = occ_r;

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Bench for fifo_rd_stage: a FIFO read-port model drives the stage and a queue-based
// model of words in flight and in hand predicts every output each cycle.
module tb_fifo_rd_stage;

    logic clk = 1'b0;
    logic rst;

    fifo_rd_stage_if #(.WIDTH(8)) bus ();

    fifo_rd_stage #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         rd_count  = 0;
    int         delivered = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] arr_q[$];
    logic       infl_m    = 1'b0;
    logic [7:0] infl_word = 8'h00;
    logic       rd_seen   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: the FIFO returns the word read last cycle, then the new inputs apply
    task automatic step(input logic rst_v, input logic ready_v, input logic stall_v);
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
        rst           = rst_v;
        bus.m_ready   = ready_v;
        bus.fifo_empty = (fifo_q.size() == 0) || stall_v;
        @(negedge clk);
        #1;
    endtask

    // Reference model: words in hand are a queue, one word may be in flight from the FIFO
    always @(negedge clk) begin : cmp
        int   occ_m;
        logic pop_m;
        logic exp_rd;
        occ_m = arr_q.size();
        check("m_valid", bus.m_valid, occ_m != 0);
        check("level", bus.level, occ_m);
        if (occ_m != 0) check("m_data_order", bus.m_data, arr_q[0]);
        pop_m  = (occ_m != 0) && bus.m_ready;
        exp_rd = rst && !bus.fifo_empty && (((occ_m + int'(infl_m)) < 2) || pop_m);
        check("fifo_rd_rule", bus.fifo_rd, exp_rd);
        check("occ_inflight_le2", (occ_m + int'(infl_m)) <= 2, 1'b1);
        check("rd_while_empty", bus.fifo_rd && bus.fifo_empty, 1'b0);
        if (pop_m) begin
            void'(arr_q.pop_front());
            delivered++;
        end
        if (infl_m) arr_q.push_back(infl_word);
        infl_m = bus.fifo_rd;
        if (bus.fifo_rd && fifo_q.size() > 0) begin
            infl_word = fifo_q[0];
            rd_count++;
        end
        rd_seen = bus.fifo_rd;
        if (!rst) begin
            arr_q.delete();
            infl_m = 1'b0;
        end
    end

    initial begin
        int rd0;
        int d0;
        rst            = 1'b0;
        bus.m_ready    = 1'b0;
        bus.fifo_dout  = 8'h00;
        bus.fifo_empty = 1'b0;
        fifo_q.push_back(8'h11);

        // Reset defaults with a non-empty FIFO
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("rst_fifo_rd", bus.fifo_rd, 1'b0);
            check("rst_m_valid", bus.m_valid, 1'b0);
            check("rst_m_data", bus.m_data, 8'h00);
            check("rst_level", bus.level, 2'd0);
        end

        // First-word latency
        step(1'b1, 1'b1, 1'b1);
        check("empty_no_rd", bus.fifo_rd, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("lat_c0_rd", bus.fifo_rd, 1'b1);
        check("lat_c0_valid", bus.m_valid, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("lat_c1_valid", bus.m_valid, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("lat_c2_valid", bus.m_valid, 1'b1);
        check("lat_c2_data", bus.m_data, 8'h11);
        step(1'b1, 1'b1, 1'b0);
        check("lat_drained", bus.m_valid, 1'b0);

        // Streaming 0x00..0x3F with no gaps
        for (int i = 0; i < 64; i++) fifo_q.push_back(8'(i));
        step(1'b1, 1'b1, 1'b0);
        check("stream_c0_rd", bus.fifo_rd, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("stream_valid", bus.m_valid, 1'b1);
            check("stream_data", bus.m_data, 8'(i));
        end
        step(1'b1, 1'b1, 1'b0);
        check("stream_end", bus.m_valid, 1'b0);

        // Back-pressure: 10 words, ready low for 20 cycles
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'hA0 + 8'(i));
        rd0 = rd_count;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i >= 2) begin
                check("bp_hold_valid", bus.m_valid, 1'b1);
                check("bp_hold_data", bus.m_data, 8'hA0);
            end
        end
        check("bp_reads", rd_count - rd0, 2);
        check("bp_level", bus.level, 2'd2);
        d0 = delivered;
        step(1'b1, 1'b1, 1'b0);
        check("bp_rd_on_pop", bus.fifo_rd, 1'b1);
        check("bp_first_data", bus.m_data, 8'hA0);
        for (int k = 0; k < 40 && (delivered - d0) < 10; k++) step(1'b1, 1'b1, 1'b0);
        check("bp_delivered", delivered - d0, 10);

        // Reset mid-stream with occ = 2 and nothing in flight
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        check("mid_level2", bus.level, 2'd2);
        step(1'b0, 1'b0, 1'b0);
        check("mid_rst_no_rd", bus.fifo_rd, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("mid_valid0", bus.m_valid, 1'b0);
        check("mid_level0", bus.level, 2'd0);
        check("mid_rd", bus.fifo_rd, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("mid_c1_valid", bus.m_valid, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("mid_c2_valid", bus.m_valid, 1'b1);
        check("mid_c2_data", bus.m_data, 8'hC2);
        for (int k = 0; k < 20 && (bus.m_valid || fifo_q.size() > 0); k++) step(1'b1, 1'b1, 1'b0);
        check("mid_drained", bus.m_valid, 1'b0);

        // Random stalls on both sides over 1000 words
        for (int i = 0; i < 1000; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
        d0 = delivered;
        for (int k = 0; k < 8000 && (delivered - d0) < 1000; k++)
            step(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        check("rand_delivered", delivered - d0, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
